// File: rtl/imem_prog_controller_pkg.sv
// Shared types and constants for the IRAM UART programming controller.
package imem_prog_pkg;

  typedef enum logic [2:0] {IDLE, HDR, LOAD, CHK, DONE, ERR} prog_state_t;

  localparam int         WORD_BYTES = 4;
  localparam logic [3:0] WEA_ALL    = 4'hF;
  localparam int         HDR_BYTES  = 4;

  // Running checksum step; wraps at 8 bits so a trailing two's-complement byte nets to zero.
  function automatic logic [7:0] byte_sum(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction

endpackage

// File: rtl/imem_prog_controller_if.sv
// UART-receive and IRAM-write signal bundle for the programming controller.
interface imem_prog_if #(
  parameter int ADDR_W = 32
);
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              imem_ena;
  logic [3:0]        imem_wea;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_din;

  modport master (
    input  rx_valid, rx_data,
    output imem_ena, imem_wea, imem_addr, imem_din
  );

  modport slave (
    output rx_valid, rx_data,
    input  imem_ena, imem_wea, imem_addr, imem_din
  );
endinterface

// File: rtl/imem_prog_controller_byte_packer.sv
// Steers LSB-first bytes into a word-wide assembly register and flags the completing byte.
module prog_byte_packer
  import imem_prog_pkg::*;
(
  input  logic                    clk,
  input  logic                    Rst,
  input  logic                    clear,
  input  logic                    byte_en,
  input  logic [7:0]              byte_in,
  output logic [WORD_BYTES*8-1:0] word_out,
  output logic                    word_done
);
  localparam int LANE_W = $clog2(WORD_BYTES);

  logic [LANE_W-1:0]          lane;
  logic [WORD_BYTES-1:0][7:0] asm_q;
  logic [WORD_BYTES-1:0][7:0] merged;

  // The completed word includes the byte arriving now, so the caller can act on the same edge.
  always_comb begin
    merged       = asm_q;
    merged[lane] = byte_in;
  end

  assign word_out  = merged;
  assign word_done = byte_en && (lane == LANE_W'(WORD_BYTES - 1));

  always_ff @(posedge clk) begin
    if (Rst || clear) begin
      lane  <= '0;
      asm_q <= '0;
    end else if (byte_en) begin
      asm_q[lane] <= byte_in;
      lane        <= lane + 1'b1;
    end
  end

endmodule

// File: rtl/imem_prog_controller.sv
// Loads IRAM from a framed UART byte stream (count, payload words, optional checksum).
// Define IMEM_PROG_CHECKSUM_EN to require a trailing mod-256 checksum byte.
module imem_prog_controller
  import imem_prog_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 1_000_000
) (
  input  logic        clk,
  input  logic        Rst,
  input  logic        start_prog,
  imem_prog_if.master bus,
  output logic        prog_ena,
  output logic        prog_done,
  output logic        prog_err,
  output logic [15:0] words_written
);
  localparam int CNT_W  = $clog2(DEPTH_WORDS + 1);
  localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);

  if (DEPTH_WORDS < 1 || DEPTH_WORDS > 65535) begin : g_depth_bad
    $error("DEPTH_WORDS must be in 1..65535 so words_written cannot wrap");
  end
  if (HDR_BYTES != WORD_BYTES) begin : g_hdr_bad
    $error("header count and payload words share the packer width");
  end

  prog_state_t       state;
  logic [CNT_W-1:0]  word_total;
  logic [IDLE_W-1:0] idle_cnt;
  logic              wr_pend;
  logic [31:0]       pack_word;
  logic              word_done;
  logic              byte_en;
  logic              pack_clear;
  logic              in_frame;
  logic              timeout_hit;
  logic              word_is_last;
`ifdef IMEM_PROG_CHECKSUM_EN
  logic [7:0]        chk_sum;
`else
  logic              wr_last;
`endif

  assign in_frame     = (state == HDR) || (state == LOAD) || (state == CHK);
  assign byte_en      = bus.rx_valid && ((state == HDR) || (state == LOAD));
  assign pack_clear   = start_prog && ((state == IDLE) || (state == ERR));
  assign timeout_hit  = in_frame && !bus.rx_valid && (idle_cnt == IDLE_W'(TIMEOUT_CYC - 1));
  assign word_is_last = (32'(words_written) + 32'd1) == 32'(word_total);

  prog_byte_packer u_packer (
    .clk       (clk),
    .Rst       (Rst),
    .clear     (pack_clear),
    .byte_en   (byte_en),
    .byte_in   (bus.rx_data),
    .word_out  (pack_word),
    .word_done (word_done)
  );

  // A pending write always retires one cycle after its 4th byte, independent of the state,
  // which leaves the packer free to take the next lane-0 byte during the write cycle.
  always_ff @(posedge clk) begin
    if (Rst) begin
      state         <= IDLE;
      prog_ena      <= 1'b0;
      prog_done     <= 1'b0;
      prog_err      <= 1'b0;
      words_written <= '0;
      word_total    <= '0;
      idle_cnt      <= '0;
      wr_pend       <= 1'b0;
      bus.imem_ena  <= 1'b0;
      bus.imem_wea  <= '0;
      bus.imem_addr <= '0;
      bus.imem_din  <= '0;
`ifdef IMEM_PROG_CHECKSUM_EN
      chk_sum       <= '0;
`else
      wr_last       <= 1'b0;
`endif
    end else begin
      bus.imem_ena <= 1'b0;
      bus.imem_wea <= '0;
      prog_done    <= 1'b0;

      if (in_frame && !bus.rx_valid) idle_cnt <= idle_cnt + 1'b1;
      else                           idle_cnt <= '0;

      if (wr_pend) begin
        wr_pend       <= 1'b0;
        words_written <= words_written + 16'd1;
      end

      case (state)
        IDLE, ERR: begin
          if (start_prog) begin
            state         <= HDR;
            prog_ena      <= 1'b1;
            prog_err      <= 1'b0;
            words_written <= '0;
            word_total    <= '0;
`ifdef IMEM_PROG_CHECKSUM_EN
            chk_sum       <= '0;
`endif
          end
        end
        HDR: begin
          if (word_done) begin
            if (pack_word == 32'd0) begin
              state <= DONE;
            end else if (pack_word > 32'(DEPTH_WORDS)) begin
              state    <= ERR;
              prog_err <= 1'b1;
              prog_ena <= 1'b0;
            end else begin
              state      <= LOAD;
              word_total <= CNT_W'(pack_word);
            end
          end
        end
        LOAD: begin
`ifdef IMEM_PROG_CHECKSUM_EN
          if (bus.rx_valid) chk_sum <= byte_sum(chk_sum, bus.rx_data);
`else
          if (wr_pend && wr_last) state <= DONE;
`endif
          if (word_done) begin
            bus.imem_ena  <= 1'b1;
            bus.imem_wea  <= WEA_ALL;
            bus.imem_addr <= ADDR_W'({words_written, 2'b00});
            bus.imem_din  <= pack_word;
            wr_pend       <= 1'b1;
`ifdef IMEM_PROG_CHECKSUM_EN
            if (word_is_last) state <= CHK;
`else
            wr_last       <= word_is_last;
`endif
          end
        end
        CHK: begin
`ifdef IMEM_PROG_CHECKSUM_EN
          if (bus.rx_valid) begin
            if (byte_sum(chk_sum, bus.rx_data) == 8'h00) begin
              state <= DONE;
            end else begin
              state    <= ERR;
              prog_err <= 1'b1;
              prog_ena <= 1'b0;
            end
          end
`else
          state <= IDLE;
`endif
        end
        DONE: begin
          prog_done <= 1'b1;
          prog_ena  <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (timeout_hit) begin
        state    <= ERR;
        prog_err <= 1'b1;
        prog_ena <= 1'b0;
      end
    end
  end

endmodule
